// File: rtl/serial_tx.sv
// ---------------------------------------------------------------------------
// serial_tx -- 8N1 asynchronous serial transmitter (configurable stop bits).
//
// Serializes one byte per txStart/txBusy handshake onto the UART TX line,
// LSB first, framed by one start bit and STOP_BITS stop bits.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per serial bit (>= 2)
//   STOP_BITS     number of stop bits (1 or 2)
//
// Ports:
//   clk      in   system clock, rising edge
//   reset_n  in   synchronous active-low reset
//   txStart  in   send request, only looked at while idle
//   txData   in   byte to send, captured on the accepting edge
//   txBusy   out  high from the cycle after acceptance until frame end
//   tx       out  serial line, idles high
//   txDone   out  one-cycle pulse in the cycle txBusy falls
// ---------------------------------------------------------------------------
module serial_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       txStart,
  input  logic [7:0] txData,
  output logic       txBusy,
  output logic       tx,
  output logic       txDone
);

  localparam int                CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;     // data bit index, reused as stop-bit index
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             bit_end;

  assign bit_end = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = bit_end ? '0 : cnt_q + CNT_W'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cnt_d  = '0;
        idx_d  = '0;
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (txStart) begin
          shift_d = txData;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          state_d = S_START;
        end
      end

      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          idx_d   = '0;
          tx_d    = shift_q[0];
        end
      end

      S_DATA: begin
        if (bit_end) begin
          if (idx_q == 3'd7) begin
            state_d = S_STOP;
            idx_d   = '0;
            tx_d    = 1'b1;
          end else begin
            // The register shifts right, so the next line value is the
            // current bit 1 (the post-shift bit 0).
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
            idx_d   = idx_q + 3'd1;
          end
        end
      end

      S_STOP: begin
        if (bit_end) begin
          if (idx_q == STOP_LAST) begin
            state_d = S_IDLE;
            idx_d   = '0;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tx     = tx_q;
  assign txBusy = busy_q;
  assign txDone = done_q;

endmodule

// File: tb/tb_serial_tx.sv
// ---------------------------------------------------------------------------
// tb_serial_tx -- self-checking bench for serial_tx.
//
// Instance A: CLKS_PER_BIT=4, STOP_BITS=1.  Instance B: CLKS_PER_BIT=5,
// STOP_BITS=2 (continuous txStart).  Expected line values come from a
// slot-based frame model: slot 0 is the start bit, slots 1..8 the data
// bits LSB first, later slots the stop bits.
// ---------------------------------------------------------------------------
module tb_serial_tx;

  localparam int CA = 4;
  localparam int CB = 5;
  localparam int SB = 2;

  logic       clk = 1'b0;
  logic       reset_n_a, txStart_a, txBusy_a, tx_a, txDone_a;
  logic [7:0] txData_a;
  logic       reset_n_b, txStart_b, txBusy_b, tx_b, txDone_b;
  logic [7:0] txData_b;

  int n_checks = 0;
  int n_fail   = 0;

  logic obs_tx[$];
  logic obs_busy[$];
  logic obs_done[$];

  // Line recorder for the burst test (negedge: away from the active edge).
  logic rec_a = 1'b0;
  logic rec_q[$];
  int   rec_done = 0;

  always #5 clk = ~clk;

  serial_tx #(.CLKS_PER_BIT(CA), .STOP_BITS(1)) dut_a (
    .clk(clk), .reset_n(reset_n_a), .txStart(txStart_a), .txData(txData_a),
    .txBusy(txBusy_a), .tx(tx_a), .txDone(txDone_a)
  );

  serial_tx #(.CLKS_PER_BIT(CB), .STOP_BITS(SB)) dut_b (
    .clk(clk), .reset_n(reset_n_b), .txStart(txStart_b), .txData(txData_b),
    .txBusy(txBusy_b), .tx(tx_b), .txDone(txDone_b)
  );

  always @(negedge clk) begin
    if (rec_a) begin
      rec_q.push_back(tx_a);
      rec_done += int'(txDone_a);
    end
  end

  // Reference: line value of a given bit slot of a frame carrying d.
  function automatic logic frame_bit(input logic [7:0] d, input int slot);
    if (slot == 0) return 1'b0;
    if (slot <= 8) return d[slot-1];
    return 1'b1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Record n cycles of instance A outputs, starting with the current cycle.
  task automatic observe_a(input int n);
    obs_tx.delete(); obs_busy.delete(); obs_done.delete();
    repeat (n) begin
      obs_tx.push_back(tx_a);
      obs_busy.push_back(txBusy_a);
      obs_done.push_back(txDone_a);
      tick();
    end
  endtask

  task automatic test_reset();
    logic [2:0] got;
    reset_n_a = 1'b0;
    repeat (3) tick();
    reset_n_a = 1'b1;
    for (int i = 0; i < 50; i++) begin
      got = {tx_a, txBusy_a, txDone_a};
      n_checks++;
      if (got !== 3'b100) begin
        n_fail++;
        $display("FAIL reset_idle cyc=%0d {tx,busy,done} got=%b exp=100", i, got);
      end
      tick();
    end
  endtask

  task automatic test_single_byte();
    logic [7:0] bytes[4];
    logic [2:0] got, exp;
    int         dones;
    bytes[0] = 8'h0C;
    for (int k = 1; k < 4; k++) bytes[k] = 8'($urandom_range(0, 255));
    for (int k = 0; k < 4; k++) begin
      txData_a  = bytes[k];
      txStart_a = 1'b1;
      tick();
      txStart_a = 1'b0;
      txData_a  = ~bytes[k];
      observe_a(48);
      dones = 0;
      for (int i = 0; i < 48; i++) begin
        got = {obs_tx[i], obs_busy[i], obs_done[i]};
        exp = {(i < 10*CA) ? frame_bit(bytes[k], i / CA) : 1'b1,
               1'(i < 10*CA), 1'(i == 10*CA)};
        dones += int'(obs_done[i]);
        n_checks++;
        if (got !== exp) begin
          n_fail++;
          $display("FAIL single_byte d=%02h cyc=%0d {tx,busy,done} got=%b exp=%b",
                   bytes[k], i, got, exp);
        end
      end
      n_checks++;
      if (dones !== 1) begin
        n_fail++;
        $display("FAIL single_byte_done d=%02h pulses got=%0d exp=1", bytes[k], dones);
      end
      $display("single_byte d=%02h checked", bytes[k]);
    end
  endtask

  task automatic test_busy_reject();
    logic [7:0] d = 8'hA5;
    logic [2:0] got, exp;
    txData_a  = d;
    txStart_a = 1'b1;
    tick();
    txStart_a = 1'b0;
    for (int i = 0; i < 64; i++) begin
      // Request inside data bit 3 (slot 4) while busy: must be ignored.
      if (i == 4*CA + 1) begin txStart_a = 1'b1; txData_a = 8'hFF; end
      if (i == 4*CA + 2) txStart_a = 1'b0;
      got = {tx_a, txBusy_a, txDone_a};
      exp = {(i < 10*CA) ? frame_bit(d, i / CA) : 1'b1,
             1'(i < 10*CA), 1'(i == 10*CA)};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL busy_reject cyc=%0d {tx,busy,done} got=%b exp=%b", i, got, exp);
      end
      tick();
    end
    $display("busy_reject d=%02h checked", d);
  endtask

  task automatic test_burst();
    logic [7:0] dec[$];
    logic [7:0] b;
    int         w, i;
    rec_q.delete();
    rec_done = 0;
    rec_a = 1'b1;
    for (int k = 0; k < 16; k++) begin
      w = 0;
      while (txBusy_a !== 1'b0 && w < 200) begin tick(); w++; end
      if (w >= 200) begin
        n_checks++; n_fail++;
        $display("FAIL burst_timeout byte=%0d busy got=%b exp=0", k, txBusy_a);
      end
      txData_a  = 8'(k);
      txStart_a = 1'b1;
      tick();
      txStart_a = 1'b0;
      tick();
      tick();
    end
    w = 0;
    while (txBusy_a !== 1'b0 && w < 200) begin tick(); w++; end
    repeat (5) tick();
    rec_a = 1'b0;
    // Behavioural receiver: sample mid-bit after each falling edge.
    i = 1;
    while (i + 9*CA + CA/2 < rec_q.size()) begin
      if (rec_q[i] == 1'b0 && rec_q[i-1] == 1'b1) begin
        for (int k = 0; k < 8; k++) b[k] = rec_q[i + CA*(k+1) + CA/2];
        n_checks++;
        if ({rec_q[i + CA/2], rec_q[i + 9*CA + CA/2]} !== 2'b01) begin
          n_fail++;
          $display("FAIL burst_framing frame=%0d {start,stop} got=%b exp=01",
                   dec.size(), {rec_q[i + CA/2], rec_q[i + 9*CA + CA/2]});
        end
        dec.push_back(b);
        i += 9*CA + CA/2;
      end else begin
        i++;
      end
    end
    n_checks++;
    if (dec.size() !== 16) begin
      n_fail++;
      $display("FAIL burst_count frames got=%0d exp=16", dec.size());
    end
    for (int k = 0; k < dec.size() && k < 16; k++) begin
      n_checks++;
      if (dec[k] !== 8'(k)) begin
        n_fail++;
        $display("FAIL burst_byte idx=%0d got=%02h exp=%02h", k, dec[k], 8'(k));
      end
    end
    n_checks++;
    if (rec_done !== 16) begin
      n_fail++;
      $display("FAIL burst_done pulses got=%0d exp=16", rec_done);
    end
    $display("burst frames=%0d done=%0d checked", dec.size(), rec_done);
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d = 8'h3C;
    logic [7:0] f;
    logic [2:0] got, exp;
    txData_a  = d;
    txStart_a = 1'b1;
    tick();
    txStart_a = 1'b0;
    repeat (6*CA + 1) tick();   // inside data bit 5
    n_checks++;
    if (tx_a !== d[5]) begin
      n_fail++;
      $display("FAIL mid_frame_bit5 tx got=%b exp=%b", tx_a, d[5]);
    end
    reset_n_a = 1'b0;
    tick();
    reset_n_a = 1'b1;
    got = {tx_a, txBusy_a, txDone_a};
    n_checks++;
    if (got !== 3'b100) begin
      n_fail++;
      $display("FAIL mid_frame_reset {tx,busy,done} got=%b exp=100", got);
    end
    observe_a(12);
    for (int i = 0; i < 12; i++) begin
      got = {obs_tx[i], obs_busy[i], obs_done[i]};
      n_checks++;
      if (got !== 3'b100) begin
        n_fail++;
        $display("FAIL mid_frame_after cyc=%0d {tx,busy,done} got=%b exp=100", i, got);
      end
    end
    f = 8'($urandom_range(0, 255));
    txData_a  = f;
    txStart_a = 1'b1;
    tick();
    txStart_a = 1'b0;
    observe_a(44);
    for (int i = 0; i < 44; i++) begin
      got = {obs_tx[i], obs_busy[i], obs_done[i]};
      exp = {(i < 10*CA) ? frame_bit(f, i / CA) : 1'b1,
             1'(i < 10*CA), 1'(i == 10*CA)};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL mid_frame_fresh d=%02h cyc=%0d {tx,busy,done} got=%b exp=%b",
                 f, i, got, exp);
      end
    end
    $display("reset_mid_frame fresh d=%02h checked", f);
  endtask

  task automatic test_back_to_back();
    localparam int FL = CB*(9+SB);   // busy cycles per frame
    localparam int PER = FL + 1;     // plus one idle-high cycle
    logic [7:0] d = 8'h55;
    logic       btx[$];
    logic       bbusy[$];
    logic       bdone[$];
    logic [2:0] got, exp;
    int         j, run, runs;
    reset_n_b = 1'b0;
    tick(); tick();
    reset_n_b = 1'b1;
    tick();
    txData_b  = d;
    txStart_b = 1'b1;
    tick();
    for (int i = 0; i < 3*PER; i++) begin
      btx.push_back(tx_b); bbusy.push_back(txBusy_b); bdone.push_back(txDone_b);
      tick();
    end
    txStart_b = 1'b0;
    for (int i = 0; i < 3*PER; i++) begin
      j   = i % PER;
      got = {btx[i], bbusy[i], bdone[i]};
      exp = {(j < FL) ? frame_bit(d, j / CB) : 1'b1, 1'(j < FL), 1'(j == FL)};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL b2b cyc=%0d {tx,busy,done} got=%b exp=%b", i, got, exp);
      end
    end
    run = 0; runs = 0;
    for (int i = 0; i < 3*PER; i++) begin
      if (bbusy[i] === 1'b1) run++;
      else if (run != 0) begin
        n_checks++;
        if (run !== 55) begin
          n_fail++;
          $display("FAIL b2b_busy_len frame=%0d got=%0d exp=55", runs, run);
        end
        runs++;
        run = 0;
      end
    end
    n_checks++;
    if (runs !== 3) begin
      n_fail++;
      $display("FAIL b2b_frames got=%0d exp=3", runs);
    end
    for (int k = 1; k < 3; k++) begin
      run = 0;
      j = k*PER - 1;
      while (j >= 0 && btx[j] === 1'b1) begin run++; j--; end
      n_checks++;
      if (run !== 11) begin
        n_fail++;
        $display("FAIL b2b_gap before frame %0d high got=%0d exp=11", k, run);
      end
    end
    $display("back_to_back frames=%0d checked", runs);
  endtask

  initial begin
    reset_n_a = 1'b0; txStart_a = 1'b0; txData_a = 8'h00;
    reset_n_b = 1'b0; txStart_b = 1'b0; txData_b = 8'h00;
    tick();
    test_reset();
    test_single_byte();
    test_busy_reject();
    test_burst();
    test_reset_mid_frame();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
